// File: rtl/memory_responder.sv
// memory_responder: word-addressed on-chip memory completing one access after a fixed LATENCY.
// Ports: clk, rst (async, active-high); mem_req/memory_addr/write_to_memory/data_to_memory request in;
//        data_from_memory (registered read data), mem_ready (completion pulse),
//        memory_error (fault flag with mem_ready), mem_busy (access pending).
module memory_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req,
    input  logic [31:0] memory_addr,
    input  logic        write_to_memory,
    input  logic [31:0] data_to_memory,
    output logic [31:0] data_from_memory,
    output logic        mem_ready,
    output logic        memory_error,
    output logic        mem_busy
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(LATENCY) + 1;
    typedef enum logic {IDLE, WAIT} state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [31:0]   wdata_q, wdata_d, rdata_q, rdata_d, off;
    logic          we_q, we_d, fault_q, fault_d, ready_q, ready_d, error_q, error_d, mem_we;
    logic [31:0]   mem_q [DEPTH_WORDS];
    assign off = memory_addr - BASE_ADDR;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        fault_d = fault_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        error_d = 1'b0;
        mem_we  = 1'b0;
        if (state_q == IDLE) begin
            if (mem_req) begin
                idx_d   = off[AW+1:2];
                wdata_d = data_to_memory;
                we_d    = write_to_memory;
                // the below-base check keeps wrapped offsets from aliasing into the array
                fault_d = (memory_addr[1:0] != 2'b00) || (memory_addr < BASE_ADDR) ||
                          ((off >> 2) >= 32'(DEPTH_WORDS));
                cnt_d   = CW'(LATENCY - 1);
                state_d = WAIT;
            end
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end else begin
            ready_d = 1'b1;
            error_d = fault_q;
            mem_we  = we_q && !fault_q;
            rdata_d = we_q ? rdata_q : (fault_q ? 32'h0 : mem_q[idx_q]);
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            fault_q <= 1'b0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            fault_q <= fault_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            error_q <= error_d;
        end
    end
    // array has no reset so its contents survive rst
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[idx_q] <= wdata_q;
    end
    assign data_from_memory = rdata_q;
    assign mem_ready        = ready_q;
    assign memory_error     = error_q;
    assign mem_busy         = (state_q != IDLE);
endmodule

// File: doc/memory_responder.md
# memory_responder

Word-addressed on-chip memory that services the CPU's memory port from the target side. It accepts one request at a time (address, direction, write data) and completes it after a fixed, parameterised latency with a one-cycle `mem_ready` pulse. Misaligned or out-of-range accesses are flagged on `memory_error` instead of touching the array. Sits between the CPU core and the rest of the MCU as its program/data store.

## Interface
- `BASE_ADDR`, 32'h0000_0000 — byte address of word 0; must be word aligned.
- `DEPTH_WORDS`, 1024 — number of 32-bit words; power of two, ≥ 2.
- `LATENCY`, 2 — cycles from request-capture edge to completion edge; ≥ 1.
- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — reset, asynchronous, active-high.
- `mem_req` in 1 — request strobe, sampled only in IDLE.
- `memory_addr` in 32 — byte address.
- `write_to_memory` in 1 — 1 = write, 0 = read.
- `data_to_memory` in 32 — write data.
- `data_from_memory` out 32 — read data, registered.
- `mem_ready` out 1 — one-cycle completion pulse.
- `memory_error` out 1 — high with `mem_ready` when the access faulted.
- `mem_busy` out 1 — high while an access is pending (state ≠ IDLE).

## Operation
- States: IDLE, WAIT. Down-counter `cnt`, width clog2(LATENCY)+1.
- IDLE, `mem_req`=1 at edge k:
  - Capture addr, direction and wdata.
  - Compute fault = (addr[1:0] ≠ 0) | (addr < BASE_ADDR) | (((addr − BASE_ADDR) >> 2) ≥ DEPTH_WORDS), using 32-bit unsigned arithmetic; capture it.
  - Set `cnt` ← LATENCY−1; go to WAIT.
- IDLE, `mem_req`=0: stay.
- WAIT, `cnt` ≠ 0: `cnt` ← `cnt`−1.
- WAIT, `cnt` = 0 (edge k+LATENCY):
  - `mem_ready` ← 1 and `memory_error` ← fault.
  - Write without fault: array[index] ← wdata; `data_from_memory` unchanged.
  - Read without fault: `data_from_memory` ← array[index].
  - Any fault: no array write; a faulting read drives `data_from_memory` ← 0.
  - Return to IDLE.
- `mem_ready` and `memory_error` clear on the following edge unless a new completion occurs there. With LATENCY ≥ 1 a new completion cannot occur on that edge.
- `data_from_memory` holds its last value until the next read completes.
- `mem_req` while busy is ignored, not queued. The initiator holds `mem_req`, address and data until `mem_ready`.
- Index = bits [clog2(DEPTH_WORDS)+1:2] of (addr − BASE_ADDR).
- The array is not reset. Contents are undefined at power-up and survive `rst`.

## Timing
- Reset values: state IDLE, `cnt` 0, `data_from_memory` 0, `mem_ready` 0, `memory_error` 0, `mem_busy` 0.
- Request captured at edge k → `mem_ready` high during cycle k+LATENCY .. k+LATENCY+1. Write commits at edge k+LATENCY.
- State is IDLE again from edge k+LATENCY, so a `mem_req` held through the `mem_ready` cycle is captured at edge k+LATENCY+1. Maximum throughput is one access per LATENCY+1 cycles.
- Read-after-write to the same address in the next access returns the new data.
- Boundary addresses:
  - BASE_ADDR+4·(DEPTH_WORDS−1) is valid.
  - BASE_ADDR+4·DEPTH_WORDS faults.
  - Address wrap near 32'hFFFF_FFFC faults (out of range), with no aliasing.
- `rst` asserted mid-WAIT: access abandoned, no array write, all outputs to reset values immediately (asynchronous).
- `mem_busy` is combinational from state; `mem_ready`, `memory_error` and `data_from_memory` are registered.

## Test plan
- Reset: hold `rst`=1 with `mem_req`=1 → `mem_ready`=0, `memory_error`=0, `mem_busy`=0, `data_from_memory`=0. No capture until `rst` drops.
- Write then read, LATENCY=2:
  - Write 32'h1234_5678 to 0x10, `mem_req` at edge k → `mem_ready` pulse at edge k+2, error 0.
  - Read 0x10 captured at edge k+3 → `mem_ready` at edge k+5, `data_from_memory`=32'h1234_5678.
- Misaligned: write 32'hFFFF_FFFF to 0x13 → `mem_ready`=1 and `memory_error`=1 for one cycle. A following read of 0x10 still returns 32'h1234_5678.
- Range, DEPTH_WORDS=1024:
  - Read 0xFFC → no error, data returned.
  - Read 0x1000 → error=1, `data_from_memory`=0.
  - BASE_ADDR=0x100 with read 0x0FC → error.
- Back-to-back, `mem_req` held high with writes to 0x0, 0x4, 0x8: completions exactly every LATENCY+1 cycles, `mem_busy` low only on each `mem_ready` cycle. Request changes while busy have no effect.
- Reset mid-access: write 32'hAAAA_5555 to 0x20, assert `rst` in the WAIT cycle → no `mem_ready`. Reading 0x20 afterwards returns the value present before the write.
